// File: rtl/aquecimento_termostato.sv
// Closed-loop wash heater: heat to target, hold with hysteresis for a set time,
// and flag a fault if the target is not reached within TEMPO_MAX_AQUEC cycles.
module aquecimento_termostato #(
  parameter int LARGURA_TEMP    = 8,
  parameter int LARGURA_TEMPO   = 8,
  parameter int HISTERESE       = 2,
  parameter int TEMPO_MAX_AQUEC = 200
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [LARGURA_TEMP-1:0]  temp_alvo,
  input  logic [LARGURA_TEMPO-1:0] tempo_manter,
  input  logic [LARGURA_TEMP-1:0]  temp_atual,
  output logic                     aquecimento,
  output logic                     pronto,
  output logic                     concluido,
  output logic                     erro,
  output logic [2:0]               estado
);

  localparam int LARG_CONT = (TEMPO_MAX_AQUEC > 1) ? $clog2(TEMPO_MAX_AQUEC) : 1;
  localparam logic [LARG_CONT-1:0] CONT_FIM = LARG_CONT'(TEMPO_MAX_AQUEC - 1);
  localparam logic [LARG_CONT-1:0] CONT_UM  = LARG_CONT'(1);
  localparam logic [LARGURA_TEMPO:0] MANTER_UM = (LARGURA_TEMPO + 1)'(1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    AQUECENDO = 3'd1,
    MANTENDO  = 3'd2,
    CONCLUIDO = 3'd3,
    ERRO      = 3'd4
  } estado_t;

  estado_t                  r_estado;
  logic                     r_aquec;
  logic                     r_pronto;
  logic                     r_concl;
  logic                     r_erro;
  logic [LARGURA_TEMP-1:0]  r_alvo;
  logic [LARGURA_TEMPO-1:0] r_manter;
  logic [LARG_CONT-1:0]     r_cont_aquec;
  logic [LARGURA_TEMPO-1:0] r_cont_manter;

  logic [LARGURA_TEMP-1:0]  w_limiar;
  logic [LARGURA_TEMPO:0]   w_cont_manter_mais1;
  logic                     w_fim_manter;

  // Lower thermostat threshold, saturating at zero for very low targets.
  always_comb begin
    w_limiar = '0;
    if (int'(r_alvo) > HISTERESE)
      w_limiar = r_alvo - LARGURA_TEMP'(HISTERESE);
  end

  assign w_cont_manter_mais1 = {1'b0, r_cont_manter} + MANTER_UM;
  assign w_fim_manter = (r_manter == '0) || (w_cont_manter_mais1 >= {1'b0, r_manter});

  // start is a level: high runs the cycle, low at any edge outside OCIOSO
  // aborts to OCIOSO. A new cycle needs start low for at least one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado      <= OCIOSO;
      r_aquec       <= 1'b0;
      r_pronto      <= 1'b0;
      r_concl       <= 1'b0;
      r_erro        <= 1'b0;
      r_alvo        <= '0;
      r_manter      <= '0;
      r_cont_aquec  <= '0;
      r_cont_manter <= '0;
    end else if (r_estado != OCIOSO && !start) begin
      r_estado      <= OCIOSO;
      r_aquec       <= 1'b0;
      r_pronto      <= 1'b0;
      r_concl       <= 1'b0;
      r_erro        <= 1'b0;
      r_cont_aquec  <= '0;
      r_cont_manter <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (start) begin
            r_alvo       <= temp_alvo;
            r_manter     <= tempo_manter;
            r_cont_aquec <= '0;
            r_estado     <= AQUECENDO;
            r_aquec      <= 1'b1;
          end
        end
        AQUECENDO: begin
          if (temp_atual >= r_alvo) begin
            r_estado      <= MANTENDO;
            r_cont_manter <= '0;
            r_aquec       <= 1'b0;
            r_pronto      <= 1'b1;
          end else if (r_cont_aquec == CONT_FIM) begin
            r_estado <= ERRO;
            r_aquec  <= 1'b0;
            r_erro   <= 1'b1;
          end else begin
            r_cont_aquec <= r_cont_aquec + CONT_UM;
          end
        end
        MANTENDO: begin
          if (w_fim_manter) begin
            r_estado <= CONCLUIDO;
            r_aquec  <= 1'b0;
            r_concl  <= 1'b1;
          end else begin
            r_cont_manter <= w_cont_manter_mais1[LARGURA_TEMPO-1:0];
            // Hysteresis band: inside it the heater keeps its last value.
            if (temp_atual < w_limiar)
              r_aquec <= 1'b1;
            else if (temp_atual >= r_alvo)
              r_aquec <= 1'b0;
          end
        end
        CONCLUIDO, ERRO: begin
          r_aquec <= 1'b0;
        end
        default: begin
          r_estado <= OCIOSO;
          r_aquec  <= 1'b0;
          r_pronto <= 1'b0;
          r_concl  <= 1'b0;
          r_erro   <= 1'b0;
        end
      endcase
    end
  end

  assign aquecimento = r_aquec;
  assign pronto      = r_pronto;
  assign concluido   = r_concl;
  assign erro        = r_erro;
  assign estado      = r_estado;

endmodule

// File: doc/aquecimento_termostato.md
# aquecimento_termostato

Parametrised heating controller for the washing-machine wash cycle. It replaces the fixed-duration heater pulse with closed-loop control: it heats until the water reaches a target temperature, holds that temperature with hysteresis for a programmable time, and flags a fault if the target is not reached within a timeout. It sits between the wash-cycle sequencer, which drives `start`, and the heater relay driver and temperature sensor interface.

## Interface
- `LARGURA_TEMP`, 8: width of the temperature inputs (unsigned).
- `LARGURA_TEMPO`, 8: width of the `tempo_manter` input and its hold counter.
- `HISTERESE`, 2: thermostat band below target, in temperature units.
- `TEMPO_MAX_AQUEC`, 200: heating timeout in cycles. Must be ≥ 1. Counter width is clog2(TEMPO_MAX_AQUEC), minimum 1.

Ports:
- `clock` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level request. High runs the cycle; low aborts it or returns the block to idle.
- `temp_alvo` input LARGURA_TEMP: target temperature. Sampled only when leaving OCIOSO.
- `tempo_manter` input LARGURA_TEMPO: hold duration in cycles. Sampled only when leaving OCIOSO.
- `temp_atual` input LARGURA_TEMP: current water temperature, already synchronous to `clock`.
- `aquecimento` output 1: heater enable (registered).
- `pronto` output 1: high in MANTENDO and CONCLUIDO.
- `concluido` output 1: high in CONCLUIDO.
- `erro` output 1: high in ERRO.
- `estado` output 3: state code. OCIOSO=0, AQUECENDO=1, MANTENDO=2, CONCLUIDO=3, ERRO=4.

## Operation
- Reset (`reset_n`=0, async) forces estado=OCIOSO, all outputs 0, all counters 0, and the latched target/hold registers 0.
- All comparisons are unsigned.
- limiar_baixo = alvo_reg − HISTERESE, saturating at 0.
- Rule at every edge in any non-OCIOSO state: `start`=0 → next state OCIOSO, aquecimento=0. This has the highest priority.
- **OCIOSO:** outputs 0.
  - `start`=1 → latch `temp_alvo` into alvo_reg and `tempo_manter` into manter_reg.
  - Then contador=0, estado=AQUECENDO, aquecimento=1.
- **AQUECENDO:** aquecimento=1. Priority order at each edge:
  1. `temp_atual` ≥ alvo_reg → MANTENDO, contador=0, aquecimento=0.
  2. contador == TEMPO_MAX_AQUEC−1 → ERRO, aquecimento=0.
  3. Otherwise contador+1.
- **MANTENDO:**
  - Leave: if manter_reg == 0 or contador+1 ≥ manter_reg → CONCLUIDO, aquecimento=0.
  - Stay: otherwise contador+1, and the thermostat sets aquecimento:
    - `temp_atual` < limiar_baixo → 1.
    - `temp_atual` ≥ alvo_reg → 0.
    - Otherwise hold the current value.
  - A temperature drop never returns the block to AQUECENDO.
- **CONCLUIDO, ERRO:** terminal. aquecimento=0. Held until `start`=0, which returns the block to OCIOSO.
- A new cycle requires `start` to go low for at least one edge, then high again.
- Counters never wrap: every counting state exits at or before its terminal count.

## Timing
- Moore outputs, all registered. Each output changes only on a `clock` edge or on `reset_n` assertion.
- Start latency: if `start` is sampled high at edge k, then aquecimento=1 and estado=1 from edge k.
- Timeout: with the target never reached, aquecimento is high for exactly TEMPO_MAX_AQUEC cycles, and erro rises at edge k+TEMPO_MAX_AQUEC.
- Target reached: if `temp_atual` ≥ alvo_reg is sampled at edge j, pronto=1 from edge j.
- Hold: the block spends max(manter_reg,1) cycles in MANTENDO.
- Abort: `start` sampled low at edge a → all outputs 0 and estado=0 after edge a.
- `temp_alvo` and `tempo_manter` changes after the OCIOSO exit are ignored.
- Reset deassertion: the first active edge sees OCIOSO.

## Test plan
- **Reset mid-heat:** TEMPO_MAX_AQUEC=8, `start`=1, `temp_atual`=20, `temp_alvo`=60; pulse `reset_n` low 3 cycles into AQUECENDO → all outputs 0 immediately, without waiting for a clock edge; estado=0.
- **Timeout:** TEMPO_MAX_AQUEC=8, `temp_atual` held at 20, `temp_alvo`=60 → aquecimento high exactly 8 cycles; erro=1 and estado=4 from the 9th edge; hold `start` 5 more cycles → erro stays 1; drop `start` → estado=0 next edge.
- **Normal cycle:** `temp_alvo`=60, `tempo_manter`=10, `temp_atual` ramps 50→60 over 5 cycles → pronto rises the edge 60 is sampled; 10 cycles of MANTENDO; concluido=1 with aquecimento=0.
- **Hysteresis:** HISTERESE=2, in MANTENDO drive `temp_atual` 60, 59, 58, 57, 58, 59, 60 → aquecimento reads 0,0,0,1,1,1,0 after each edge.
- **Boundaries:**
  - `tempo_manter`=0 → exactly 1 cycle in MANTENDO.
  - `temp_alvo`=1 with HISTERESE=2 → limiar_baixo=0, so aquecimento never re-asserts.
  - `temp_atual` ≥ target on the first AQUECENDO edge → MANTENDO after 1 heating cycle.
- **Abort and relatch:** `start` low for 1 cycle mid-MANTENDO → OCIOSO; re-raise `start` with `temp_alvo`=40 → the new target is latched, and later `temp_alvo` changes have no effect.
